// File: rtl/wam_deb.sv
// Switch conditioning for whac-a-mole: two-flop sync, then a per-channel
// debounce FSM producing clean levels plus one-cycle rise/fall pulses.

module wam_deb_ch #(
  parameter int DEB_CYC = 1000000,
  parameter int CW      = 20
) (
  input  logic clk,
  input  logic clr,
  input  logic s2,
  output logic db,
  output logic rise,
  output logic fall,
  output logic rise_nxt
);
  typedef enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L} state_t;

  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            db_nxt, fall_nxt, done;

  assign done = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= LOW;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      db    <= db_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOW:   if (s2)  state_nxt = CHK_H;
      CHK_H: if (!s2) state_nxt = LOW;
             else if (done) state_nxt = HIGH;
      HIGH:  if (!s2) state_nxt = CHK_L;
      CHK_L: if (s2)  state_nxt = HIGH;
             else if (done) state_nxt = LOW;
    endcase
  end

  // Counter clears on entry, abort and acceptance; it only advances while checking.
  always_comb begin
    cnt_nxt  = '0;
    db_nxt   = db;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    case (state)
      CHK_H: if (s2) begin
        if (done) begin
          db_nxt   = 1'b1;
          rise_nxt = 1'b1;
        end else cnt_nxt = cnt + CW'(1);
      end
      CHK_L: if (!s2) begin
        if (done) begin
          db_nxt   = 1'b0;
          fall_nxt = 1'b1;
        end else cnt_nxt = cnt + CW'(1);
      end
      default: ;
    endcase
  end
endmodule

module wam_deb #(
  parameter int N       = 8,
  parameter int DEB_CYC = 1000000,
  parameter int CW      = 20
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] sw,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         any_rise
);
  logic [N-1:0] s1, s2, rise_nxt;

  always_ff @(posedge clk) begin
    if (clr) begin
      s1       <= '0;
      s2       <= '0;
      any_rise <= 1'b0;
    end else begin
      s1       <= sw;
      s2       <= s1;
      any_rise <= |rise_nxt;
    end
  end

  wam_deb_ch #(.DEB_CYC(DEB_CYC), .CW(CW)) u_ch [N-1:0] (
    .clk      (clk),
    .clr      (clr),
    .s2       (s2),
    .db       (sw_db),
    .rise     (rise),
    .fall     (fall),
    .rise_nxt (rise_nxt)
  );
endmodule

// File: tb/tb_wam_deb.sv
// Directed + random bench for wam_deb with a run-length reference model
// feeding an expected-output queue.

module tb_wam_deb;
  localparam int N   = 8;
  localparam int DEB = 4;
  localparam int CW  = 3;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [N-1:0] sw  = '0;
  logic [N-1:0] sw_db, rise, fall;
  logic         any_rise;

  wam_deb #(.N(N), .DEB_CYC(DEB), .CW(CW)) dut (
    .clk(clk), .clr(clr), .sw(sw), .sw_db(sw_db),
    .rise(rise), .fall(fall), .any_rise(any_rise)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       any;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m1 = '0, m2 = '0, mdb = '0, pol = '0;
  int         run[N];
  int         nr, nf, nd;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a level is accepted after DEB+1 consecutive synced samples
  // that differ from the current debounced level.
  task automatic tick(input logic [7:0] s, input logic c);
    exp_t e, got;
    sw  = s;
    clr = c;
    @(posedge clk);
    e = '0;
    if (c) begin
      m1 = '0; m2 = '0; mdb = '0; pol = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m2[i] != mdb[i]) begin
          run[i]++;
          if (run[i] == DEB + 1) begin
            mdb[i] = ~mdb[i];
            run[i] = 0;
            if (mdb[i]) e.rise[i] = 1'b1;
            else        e.fall[i] = 1'b1;
          end
        end else run[i] = 0;
      end
      m2 = m1;
      m1 = s;
    end
    e.db  = mdb;
    e.any = |e.rise;
    q.push_back(e);
    #1;
    got = q.pop_front();
    chk("sw_db", sw_db, got.db);
    chk("rise", rise, got.rise);
    chk("fall", fall, got.fall);
    chk("any_rise", {7'b0, any_rise}, {7'b0, got.any});
    chk("rise_and_fall", rise & fall, 8'h00);
    for (int i = 0; i < N; i++) begin
      if (rise[i] === 1'b1) begin
        chk("rise_alternation", {7'b0, pol[i]}, 8'h00);
        pol[i] = 1'b1;
      end
      if (fall[i] === 1'b1) begin
        chk("fall_alternation", {7'b0, pol[i]}, 8'h01);
        pol[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [7:0] r;
    for (int i = 0; i < N; i++) run[i] = 0;

    // reset
    tick(8'h00, 1'b1);
    chk("rst_db", sw_db, 8'h00);
    chk("rst_rise", rise, 8'h00);
    tick(8'h00, 1'b1);
    chk("rst_any", {7'b0, any_rise}, 8'h00);

    // clean press: pulse at E+6 only
    for (int k = 0; k < 7; k++) begin
      tick(8'h01, 1'b0);
      if (k == 5) chk("press_early", rise, 8'h00);
      if (k == 6) begin
        chk("press_rise", rise, 8'h01);
        chk("press_db", sw_db, 8'h01);
        chk("press_any", {7'b0, any_rise}, 8'h01);
      end
    end
    tick(8'h01, 1'b0);
    chk("press_pulse_end", rise, 8'h00);

    // bounce on bit 3
    nr = 0; nf = 0;
    tick(8'h09, 1'b0); nr += rise[3]; nf += fall[3];
    tick(8'h01, 1'b0); nr += rise[3]; nf += fall[3];
    tick(8'h09, 1'b0); nr += rise[3]; nf += fall[3];
    tick(8'h01, 1'b0); nr += rise[3]; nf += fall[3];
    for (int k = 0; k < 12; k++) begin
      tick(8'h09, 1'b0);
      nr += rise[3]; nf += fall[3];
    end
    chk("bounce_rise_cnt", 8'(nr), 8'd1);
    chk("bounce_fall_cnt", 8'(nf), 8'd0);

    // short glitch on bit 5
    nr = 0; nf = 0; nd = 0;
    for (int k = 0; k < 13; k++) begin
      tick((k < 3) ? 8'h29 : 8'h09, 1'b0);
      nr += rise[5]; nf += fall[5]; nd += sw_db[5];
    end
    chk("glitch_rise", 8'(nr), 8'd0);
    chk("glitch_fall", 8'(nf), 8'd0);
    chk("glitch_db", 8'(nd), 8'd0);

    // release bit 7 from all-high
    for (int k = 0; k < 10; k++) tick(8'hFF, 1'b0);
    chk("all_high_db", sw_db, 8'hFF);
    nr = 0;
    for (int k = 0; k < 7; k++) begin
      tick(8'h7F, 1'b0);
      nr += $countones(rise);
      if (k == 6) begin
        chk("release_fall", fall, 8'h80);
        chk("release_db", sw_db, 8'h7F);
      end
    end
    chk("release_no_rise", 8'(nr), 8'd0);

    // simultaneous press
    for (int k = 0; k < 10; k++) tick(8'h00, 1'b0);
    chk("all_low_db", sw_db, 8'h00);
    for (int k = 0; k < 7; k++) tick(8'hFF, 1'b0);
    chk("simul_rise", rise, 8'hFF);
    chk("simul_any", {7'b0, any_rise}, 8'h01);
    tick(8'hFF, 1'b0);
    chk("simul_any_end", {7'b0, any_rise}, 8'h00);

    // reset mid-count: clr sampled at E+4, clr low first sampled at E+5
    for (int k = 0; k < 10; k++) tick(8'h00, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick(8'hFF, k == 4);
      if (k == 6)  chk("clr_mid_no_pulse", rise, 8'h00);
      if (k == 10) chk("clr_mid_early", rise, 8'h00);
      if (k == 11) chk("clr_mid_rise", rise, 8'hFF);
    end

    // random soak with bursty bounce and stable stretches
    r = 8'hFF;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) r = r ^ 8'($urandom & $urandom);
      tick(r, ($urandom_range(0, 199) == 0));
    end
    for (int k = 0; k < 10; k++) tick(r, 1'b0);
    chk("soak_settled", sw_db, r);
    chk("sb_empty", 8'(q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
